// File: rtl/pipelined_mem_responder.sv
// Memory-side responder for a valid/ready core memory port.
// Writes update an internal word RAM with byte enables.
// Reads capture RAM data at acceptance and queue it with the echoed address
// and a timestamp. Each read is presented after LATENCY cycles, in issue order.
// A stalled response holds the output register and back-pressures via ready.
module pipelined_mem_responder #(
  parameter int CORE           = 0,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 20,
  parameter int NUM_BYTES      = DATA_WIDTH / 8,
  parameter int LOG2_NUM_BYTES = $clog2(NUM_BYTES),
  parameter int MEM_WORDS      = 1024,
  parameter int LATENCY        = 2,
  parameter int QUEUE_DEPTH    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDRESS_BITS-1:0] address,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_BYTES-1:0]    byte_en,
  input  logic                    stall,
  output logic                    ready,
  output logic                    valid,
  output logic [ADDRESS_BITS-1:0] address_out,
  output logic [DATA_WIDTH-1:0]   out_data
);

  localparam int WIDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
  // Two spare bits beyond LATENCY keep the modular age unambiguous until an
  // entry is marked ripe; after that the ripe flag carries the information.
  localparam int TS_W   = $clog2(LATENCY) + 2;
  localparam logic [31:0] CORE_ID = 32'(CORE);

  // Word RAM (contents survive reset)
  logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

  // Read queue storage
  logic [DATA_WIDTH-1:0]   q_data_reg [QUEUE_DEPTH];
  logic [ADDRESS_BITS-1:0] q_addr_reg [QUEUE_DEPTH];
  logic [TS_W-1:0]         q_ts_reg   [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]  ripe_reg;
  logic [QUEUE_DEPTH-1:0]  ripe_next;
  logic [QUEUE_DEPTH-1:0]  matured;
  logic [TS_W-1:0]         age        [QUEUE_DEPTH];

  logic [PTR_W-1:0]        wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]        rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic [TS_W-1:0]         ts_reg;

  logic                    valid_reg;
  logic [ADDRESS_BITS-1:0] address_out_reg;
  logic [DATA_WIDTH-1:0]   out_data_reg;

  logic [WIDX_W-1:0]       word_idx;
  logic                    wr_accept;
  logic                    rd_accept;
  logic                    head_ready;
  logic                    load;

  // Upper address bits only alias the RAM; CORE is identification only.
  logic                    unused_bits;
  assign unused_bits = ^{address[ADDRESS_BITS-1:LOG2_NUM_BYTES+WIDX_W], CORE_ID[0]};

  assign word_idx  = address[LOG2_NUM_BYTES +: WIDX_W];
  assign ready     = ~reset & (count_reg < CNT_W'(QUEUE_DEPTH));
  assign wr_accept = write & ready;
  // A simultaneous write wins; the read half of the request is dropped.
  assign rd_accept = read & ~write & ready;

  // Per-entry aging: an entry is ripe once it has waited LATENCY cycles.
  // The sticky flag keeps long-stalled entries ripe across timestamp wrap.
  generate
    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_age
      assign age[gi]       = ts_reg - q_ts_reg[gi];
      assign matured[gi]   = ripe_reg[gi] | (age[gi] >= TS_W'(LATENCY));
      assign ripe_next[gi] = (rd_accept && (wr_ptr_reg == PTR_W'(gi))) ? 1'b0 : matured[gi];
    end
  endgenerate

  assign head_ready = (count_reg != '0) & matured[rd_ptr_reg];
  assign load       = head_ready & (~valid_reg | ~stall);

  // Pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (rd_accept) begin
      wr_ptr_next = (wr_ptr_reg == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
    if (load) begin
      rd_ptr_next = (rd_ptr_reg == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
    end
    count_next = count_reg + CNT_W'(rd_accept) - CNT_W'(load);
  end

  // RAM byte-enabled write port
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][b*8 +: 8] <= in_data[b*8 +: 8];
        end
      end
    end
  end

  // Registered RAM read into the queue payload at read acceptance
  always_ff @(posedge clock) begin
    if (rd_accept) begin
      q_data_reg[wr_ptr_reg] <= mem[word_idx];
      q_addr_reg[wr_ptr_reg] <= address;
    end
  end

  // Queue control state, timestamps and free-running time base
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ts_reg     <= '0;
      ripe_reg   <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_ts_reg[i] <= '0;
      end
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ts_reg     <= ts_reg + TS_W'(1);
      ripe_reg   <= ripe_next;
      if (rd_accept) begin
        q_ts_reg[wr_ptr_reg] <= ts_reg;
      end
    end
  end

  // Output register: load ripe head when free or being consumed, hold under stall
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg       <= 1'b0;
      address_out_reg <= '0;
      out_data_reg    <= '0;
    end else if (load) begin
      valid_reg       <= 1'b1;
      address_out_reg <= q_addr_reg[rd_ptr_reg];
      out_data_reg    <= q_data_reg[rd_ptr_reg];
    end else if (valid_reg && !stall) begin
      valid_reg       <= 1'b0;
    end
  end

  assign valid       = valid_reg;
  assign address_out = address_out_reg;
  assign out_data    = out_data_reg;

endmodule

// File: tb/tb_pipelined_mem_responder.sv
// Directed testbench for pipelined_mem_responder (default parameters).
module tb_pipelined_mem_responder;
  localparam int DW = 32;
  localparam int AW = 20;
  localparam int NB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          read;
  logic          write;
  logic [AW-1:0] address;
  logic [DW-1:0] in_data;
  logic [NB-1:0] byte_en;
  logic          stall;
  logic          ready;
  logic          valid;
  logic [AW-1:0] address_out;
  logic [DW-1:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  pipelined_mem_responder #(
    .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .NUM_BYTES(NB),
    .LOG2_NUM_BYTES(2), .MEM_WORDS(1024), .LATENCY(2), .QUEUE_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .in_data(in_data), .byte_en(byte_en), .stall(stall),
    .ready(ready), .valid(valid), .address_out(address_out), .out_data(out_data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    read = 1'b0; write = 1'b1; address = a; in_data = d; byte_en = be;
    $display("wr  addr=%h data=%h be=%h", a, d, be);
    tick();
    write = 1'b0; byte_en = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; read = 1'b0; write = 1'b0; stall = 1'b0;
    address = '0; in_data = '0; byte_en = '0;
    tick(); tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_cmp++; if (address_out !== '0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", address_out); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", out_data); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_in_reset: got %b expected 0", ready); end
    reset = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after: got %b expected 1", ready); end
  endtask

  task automatic test_write_read();
    do_write(20'h00010, 32'hDEADBEEF, 4'hF);
    read = 1'b1; address = 20'h00010;
    $display("rd  addr=%h", address);
    tick();
    read = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL wr_rd_lat1: got valid %b expected 0", valid); end
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL wr_rd_lat2: got valid %b expected 0", valid); end
    tick();
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL wr_rd_valid: got %b expected 1", valid); end
    n_cmp++; if (out_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_rd_data: got %h expected deadbeef", out_data); end
    n_cmp++; if (address_out !== 20'h00010) begin n_bad++; $display("FAIL wr_rd_addr: got %h expected 00010", address_out); end
    $display("rsp addr=%h data=%h", address_out, out_data);
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL wr_rd_drain: got valid %b expected 0", valid); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 8; i++) do_write(AW'(i * 4), 32'hA5000000 + DW'(i), 4'hF);
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        read = 1'b1; address = AW'(c * 4);
        $display("rd  addr=%h", address);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready c=%0d: got %b expected 1", c, ready); end
      end else begin
        read = 1'b0;
      end
      tick();
      if (c >= 2 && c <= 9) begin
        exp_a = AW'((c - 2) * 4);
        exp_d = 32'hA5000000 + DW'(c - 2);
        n_cmp++; if (valid !== 1'b1 || address_out !== exp_a || out_data !== exp_d) begin
          n_bad++; $display("FAIL b2b_rsp c=%0d: got v=%b a=%h d=%h expected v=1 a=%h d=%h", c, valid, address_out, out_data, exp_a, exp_d);
        end
        $display("rsp addr=%h data=%h", address_out, out_data);
      end else begin
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle c=%0d: got valid %b expected 0", c, valid); end
      end
    end
  endtask

  task automatic test_stall_backpressure();
    int accepts = 0;
    logic [AW-1:0] exp_a;
    stall = 1'b1;
    for (int c = 0; c < 20 && ready; c++) begin
      read = 1'b1; address = AW'(accepts * 4);
      $display("rd  addr=%h (stalled)", address);
      tick();
      accepts++;
    end
    n_cmp++; if (accepts !== 5) begin n_bad++; $display("FAIL stall_accepts: got %0d expected 5", accepts); end
    n_cmp++; if (valid !== 1'b1 || address_out !== 20'h0) begin n_bad++; $display("FAIL stall_head: got v=%b a=%h expected v=1 a=00000", valid, address_out); end
    read = 1'b1; address = 20'h00014;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready_low c=%0d: got %b expected 0", c, ready); end
      n_cmp++; if (valid !== 1'b1 || address_out !== 20'h0 || out_data !== 32'hA5000000) begin
        n_bad++; $display("FAIL stall_hold c=%0d: got v=%b a=%h d=%h expected v=1 a=00000 d=a5000000", c, valid, address_out, out_data);
      end
    end
    read = 1'b0; stall = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready_pre_xfer: got %b expected 0", ready); end
    for (int k = 1; k < 5; k++) begin
      tick();
      if (k == 1) begin
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL stall_ready_reassert: got %b expected 1", ready); end
      end
      exp_a = AW'(k * 4);
      n_cmp++; if (valid !== 1'b1 || address_out !== exp_a || out_data !== 32'hA5000000 + DW'(k)) begin
        n_bad++; $display("FAIL stall_release k=%0d: got v=%b a=%h d=%h expected a=%h", k, valid, address_out, out_data, exp_a);
      end
      $display("rsp addr=%h data=%h", address_out, out_data);
    end
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL stall_drain: got valid %b expected 0", valid); end
  endtask

  task automatic test_byte_en_alias();
    do_write(20'h00020, 32'h11223344, 4'hF);
    do_write(20'h00020, 32'hAA000000, 4'b1000);
    read = 1'b1; address = 20'h00020;
    $display("rd  addr=%h", address);
    tick();
    address = 20'h01020;
    $display("rd  addr=%h", address);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL be_lat: got valid %b expected 0", valid); end
    tick();
    read = 1'b0;
    tick();
    n_cmp++; if (valid !== 1'b1 || address_out !== 20'h00020 || out_data !== 32'hAA223344) begin
      n_bad++; $display("FAIL be_merge: got v=%b a=%h d=%h expected v=1 a=00020 d=aa223344", valid, address_out, out_data);
    end
    tick();
    n_cmp++; if (valid !== 1'b1 || address_out !== 20'h01020 || out_data !== 32'hAA223344) begin
      n_bad++; $display("FAIL be_alias: got v=%b a=%h d=%h expected v=1 a=01020 d=aa223344", valid, address_out, out_data);
    end
    tick();
  endtask

  task automatic test_read_write_conflict();
    read = 1'b1; write = 1'b1; address = 20'h00040; in_data = 32'h5; byte_en = 4'hF;
    $display("rw  addr=%h data=%h", address, in_data);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rw_ready: got %b expected 1", ready); end
    tick();
    read = 1'b0; write = 1'b0; byte_en = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rw_no_rsp c=%0d: got valid %b expected 0", c, valid); end
    end
    read = 1'b1; address = 20'h00040;
    $display("rd  addr=%h", address);
    tick();
    read = 1'b0;
    tick(); tick();
    n_cmp++; if (valid !== 1'b1 || address_out !== 20'h00040 || out_data !== 32'h5) begin
      n_bad++; $display("FAIL rw_readback: got v=%b a=%h d=%h expected v=1 a=00040 d=00000005", valid, address_out, out_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      read = 1'b1; address = AW'(i * 4);
      $display("rd  addr=%h (stalled)", address);
      tick();
    end
    read = 1'b0;
    n_cmp++; if (valid !== 1'b1 || address_out !== 20'h0) begin n_bad++; $display("FAIL rstmid_pre: got v=%b a=%h expected v=1 a=00000", valid, address_out); end
    reset = 1'b1;
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready_in_reset: got %b expected 0", ready); end
    tick();
    n_cmp++; if (valid !== 1'b0 || address_out !== '0 || out_data !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: got v=%b a=%h d=%h expected all 0", valid, address_out, out_data);
    end
    reset = 1'b0; stall = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready_after: got %b expected 1", ready); end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale c=%0d: got valid %b expected 0", c, valid); end
    end
    read = 1'b1; address = 20'h00020;
    $display("rd  addr=%h", address);
    tick();
    read = 1'b0;
    tick(); tick();
    n_cmp++; if (valid !== 1'b1 || out_data !== 32'hAA223344) begin
      n_bad++; $display("FAIL rstmid_ram_kept: got v=%b d=%h expected v=1 d=aa223344", valid, out_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_stall_backpressure();
    test_byte_en_alias();
    test_read_write_conflict();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
